// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader and the fetch stage: widths,
// frame marker and loader state encoding.
package prog_loader_pkg;

  localparam int unsigned PL_ADDR_W    = 8;
  localparam int unsigned PL_DATA_W    = 15;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned STATE_W      = 3;
  localparam logic [7:0]  PL_SYNC_BYTE = 8'hA5;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_SYNC  = 3'd0;
  localparam state_t S_COUNT = 3'd1;
  localparam state_t S_HI    = 3'd2;
  localparam state_t S_LO    = 3'd3;
  localparam state_t S_WR    = 3'd4;
  localparam state_t S_CSUM  = 3'd5;
  localparam state_t S_DONE  = 3'd6;
  localparam state_t S_ERR   = 3'd7;

  // COUNT byte 0 encodes 256 words; the 8-bit wrap of n - 1 covers that case.
  function automatic logic is_last_word(input logic [BYTE_W-1:0] word_cnt,
                                        input logic [BYTE_W-1:0] n_words);
    return word_cnt == (n_words - BYTE_W'(1));
  endfunction

endpackage

// File: rtl/prog_loader_csum.sv
// loader_csum: 8-bit XOR accumulator with synchronous clear and enable.
module loader_csum
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0] csum_o
);

  logic [BYTE_W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if (clr_i) begin
      csum_q <= '0;
    end else if (en_i) begin
      csum_q <= csum_q ^ data_i;
    end
  end

  assign csum_o = csum_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles framed words into instruction RAM
// and holds the CPU in reset until a checksum-verified image is present.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = PL_ADDR_W,
  parameter int unsigned DATA_W    = PL_DATA_W,
  parameter logic [7:0]  SYNC_BYTE = PL_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   count_q, count_d;
  logic [BYTE_W-1:0]   wcnt_q, wcnt_d;
  logic [6:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                accept;
  logic                csum_clr, csum_en;
  logic [BYTE_W-1:0]   csum;

  loader_csum u_csum (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (csum_clr),
    .en_i   (csum_en),
    .data_i (in_data),
    .csum_o (csum)
  );

  // in_ready_q always mirrors the decode of state_q, so it doubles as the accept qualifier.
  assign accept = in_valid && in_ready_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wcnt_d   = wcnt_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    csum_clr = 1'b0;
    csum_en  = 1'b0;

    case (state_q)
      S_SYNC: begin
        if (accept && (in_data == SYNC_BYTE)) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (accept) begin
          count_d  = in_data;
          wcnt_d   = '0;
          addr_d   = '0;
          csum_clr = 1'b1;
          state_d  = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          if (in_data[7]) begin
            state_d = S_ERR;
          end else begin
            hi_d    = in_data[6:0];
            csum_en = 1'b1;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          csum_en = 1'b1;
          wdata_d = DATA_W'({hi_q, in_data});
          state_d = S_WR;
        end
      end
      S_WR: begin
        addr_d  = addr_q + ADDR_W'(1);
        wcnt_d  = wcnt_q + BYTE_W'(1);
        state_d = is_last_word(wcnt_q, count_q) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (accept) state_d = (in_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        if (accept && (in_data == SYNC_BYTE)) state_d = S_COUNT;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase

    // Status outputs are registered from the next state so they track state_q.
    in_ready_d = (state_d != S_WR) && (state_d != S_ERR);
    mem_we_d   = (state_d == S_WR);
    cpu_hold_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_SYNC;
      count_q    <= '0;
      wcnt_q     <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b1;
      mem_we_q   <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wcnt_q     <= wcnt_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as frames
// are sent and checked by a write monitor.
module tb_prog_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [14:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [14:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int  nchk = 0;
  int  npass = 0;
  int  wr_seen = 0;
  bit  gap = 1'b0;
  wr_t exp_q[$];

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Write monitor: every mem_we pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      wr_t e;
      wr_seen++;
      nchk++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: got addr=%02h data=%04h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data)
          $display("FAIL write_match: got addr=%02h data=%04h, expected addr=%02h data=%04h",
                   mem_addr, mem_wdata, e.addr, e.data);
        else
          npass++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nchk++;
      $display("FAIL send_timeout: in_ready=%0b for byte %02h, expected 1 within 50 cycles", in_ready, b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    nchk++;
    if (exp_q.size() != 0)
      $display("FAIL %s_pending: got %0d writes outstanding, expected 0", name, exp_q.size());
    else
      npass++;
  endtask

  task automatic send_basic_frame();
    exp_q.push_back('{addr: 8'h00, data: 15'h1234});
    exp_q.push_back('{addr: 8'h01, data: 15'h0ABC});
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h0A); send_byte(8'hBC);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    nchk++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !==
        {1'b1, 1'b0, 8'h00, 15'h0000, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_values: got rdy=%0b we=%0b addr=%02h wd=%04h hold=%0b done=%0b err=%0b, expected 1 0 00 0000 1 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
    else
      npass++;
  endtask

  task automatic test_basic();
    do_reset();
    exp_q.push_back('{addr: 8'h00, data: 15'h1234});
    exp_q.push_back('{addr: 8'h01, data: 15'h0ABC});
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    nchk++;
    if (mem_we !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL basic_latency: got we=%0b rdy=%0b, expected we=1 rdy=0", mem_we, in_ready);
    else
      npass++;
    send_byte(8'h0A); send_byte(8'hBC);
    nchk++;
    if (done !== 1'b0 || cpu_hold !== 1'b1)
      $display("FAIL basic_pre_done: got done=%0b hold=%0b, expected 0 1", done, cpu_hold);
    else
      npass++;
    send_byte(8'h90);
    nchk++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0)
      $display("FAIL basic_done: got done=%0b hold=%0b err=%0b, expected 1 0 0", done, cpu_hold, error);
    else
      npass++;
    drain("basic");
  endtask

  task automatic test_reload();
    // Continues from a loaded image.
    exp_q.push_back('{addr: 8'h00, data: 15'h0007});
    send_byte(8'hA5);
    nchk++;
    if (cpu_hold !== 1'b1 || done !== 1'b0)
      $display("FAIL reload_hold: got hold=%0b done=%0b, expected 1 0", cpu_hold, done);
    else
      npass++;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h07); send_byte(8'h07);
    nchk++;
    if (done !== 1'b1 || cpu_hold !== 1'b0)
      $display("FAIL reload_done: got done=%0b hold=%0b, expected 1 0", done, cpu_hold);
    else
      npass++;
    drain("reload");
  endtask

  task automatic test_bad_csum();
    int w0;
    do_reset();
    send_basic_frame();
    send_byte(8'h91);
    nchk++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL badcsum_err: got err=%0b hold=%0b rdy=%0b done=%0b, expected 1 1 0 0",
               error, cpu_hold, in_ready, done);
    else
      npass++;
    w0 = wr_seen;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = (i == 3) ? 8'hA5 : 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    nchk++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || wr_seen != w0)
      $display("FAIL badcsum_sticky: got err=%0b hold=%0b rdy=%0b writes=%0d, expected 1 1 0 %0d",
               error, cpu_hold, in_ready, wr_seen, w0);
    else
      npass++;
    drain("badcsum");
  endtask

  task automatic test_garbage();
    do_reset();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_basic_frame();
    send_byte(8'h90);
    nchk++;
    if (done !== 1'b1 || cpu_hold !== 1'b0)
      $display("FAIL garbage_done: got done=%0b hold=%0b, expected 1 0", done, cpu_hold);
    else
      npass++;
    drain("garbage");
  endtask

  task automatic test_full256();
    int w0;
    do_reset();
    w0 = wr_seen;
    send_byte(8'hA5); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{addr: 8'(i), data: 15'(i)});
      send_byte(8'h00);
      send_byte(8'(i));
    end
    @(posedge clk);
    #1;
    nchk++;
    if (mem_addr !== 8'h00 || in_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL full_wrap: got addr=%02h rdy=%0b done=%0b, expected 00 1 0", mem_addr, in_ready, done);
    else
      npass++;
    send_byte(8'h00);
    nchk++;
    if (done !== 1'b1 || wr_seen - w0 != 256)
      $display("FAIL full_done: got done=%0b writes=%0d, expected 1 256", done, wr_seen - w0);
    else
      npass++;
    drain("full");
  endtask

  task automatic test_hi_err();
    int w0;
    do_reset();
    w0 = wr_seen;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h80);
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || wr_seen != w0)
      $display("FAIL hierr: got err=%0b hold=%0b writes=%0d, expected 1 1 %0d", error, cpu_hold, wr_seen, w0);
    else
      npass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    exp_q.push_back('{addr: 8'h00, data: 15'h1234});
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    nchk++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !==
        {1'b1, 1'b0, 8'h00, 15'h0000, 1'b1, 1'b0, 1'b0})
      $display("FAIL midreset_values: got rdy=%0b we=%0b addr=%02h wd=%04h hold=%0b done=%0b err=%0b, expected 1 0 00 0000 1 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
    else
      npass++;
    drain("midreset_first");
    send_basic_frame();
    send_byte(8'h90);
    nchk++;
    if (done !== 1'b1 || cpu_hold !== 1'b0)
      $display("FAIL midreset_reload: got done=%0b hold=%0b, expected 1 0", done, cpu_hold);
    else
      npass++;
    drain("midreset");
  endtask

  task automatic test_toggle_valid();
    do_reset();
    gap = 1'b1;
    send_basic_frame();
    send_byte(8'h90);
    gap = 1'b0;
    nchk++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0)
      $display("FAIL toggle_done: got done=%0b hold=%0b err=%0b, expected 1 0 0", done, cpu_hold, error);
    else
      npass++;
    drain("toggle");
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_basic();
    test_reload();
    test_bad_csum();
    test_garbage();
    test_full256();
    test_hi_err();
    test_reset_mid();
    test_toggle_valid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
